// File: rtl/processador_multiciclo.sv
// Multi-cycle processor core: fetches one instruction per run/done handshake and
// executes it in 2 steps (moves) or 4 steps (ALU ops) over a single internal bus.
module processador_multiciclo #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [DATA_W-1:0] Din,
  output logic              done,
  output logic [DATA_W-1:0] BusWires,
  output logic              zero_flag,
  output logic              carry_flag,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int RW = $clog2(NREGS);

  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_e;
  typedef enum logic [2:0] {
    OP_MV, OP_MVT, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_MVNZ, OP_CMP
  } op_e;

  tstep_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic              wr_en;

  // Instruction fields; register indices keep only the bits NREGS needs.
  op_e               op;
  logic              imm_sel;
  logic [RW-1:0]     rx, ry;
  logic [DATA_W-1:0] imm, mvt_val, opb;
  logic [DATA_W:0]   sum, diff;
  logic              is_move;

  assign op      = op_e'(ir_q[DATA_W-1 -: 3]);
  assign imm_sel = ir_q[DATA_W-4];
  assign rx      = ir_q[DATA_W-7 +: RW];
  assign ry      = ir_q[RW-1:0];
  assign imm     = {7'b0, ir_q[DATA_W-8:0]};
  assign mvt_val = {ir_q[7:0], {(DATA_W-8){1'b0}}};
  assign opb     = imm_sel ? imm : regs_q[ry];
  assign sum     = {1'b0, a_q} + {1'b0, opb};
  assign diff    = {1'b0, a_q} - {1'b0, opb};
  assign is_move = (op == OP_MV) || (op == OP_MVT) || (op == OP_MVNZ);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    g_d      = g_q;
    z_d      = z_q;
    c_d      = c_q;
    wr_en    = 1'b0;
    done     = 1'b0;
    BusWires = '0;
    unique case (state_q)
      T0: begin
        if (run) begin
          ir_d    = Din;
          state_d = T1;
        end
      end
      T1: begin
        if (is_move) begin
          BusWires = (op == OP_MVT) ? mvt_val : opb;
          wr_en    = (op != OP_MVNZ) || !z_q;
          done     = 1'b1;
          state_d  = T0;
        end else begin
          BusWires = regs_q[rx];
          a_d      = regs_q[rx];
          state_d  = T2;
        end
      end
      T2: begin
        unique case (op)
          OP_ADD:         begin g_d = sum[DATA_W-1:0];  c_d = sum[DATA_W];   end
          OP_SUB, OP_CMP: begin g_d = diff[DATA_W-1:0]; c_d = ~diff[DATA_W]; end
          OP_AND:         g_d = a_q & opb;
          OP_XOR:         g_d = a_q ^ opb;
          default:        g_d = g_q;
        endcase
        z_d     = (g_d == '0);
        state_d = T3;
      end
      T3: begin
        BusWires = g_q;
        wr_en    = (op != OP_CMP);
        done     = 1'b1;
        state_d  = T0;
      end
      default: state_d = T0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // NOTE: the register file is architecturally cleared by reset, so it is built from
  // resettable flops rather than a RAM macro.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rx] <= BusWires;
    end
  end

  assign zero_flag  = z_q;
  assign carry_flag = c_q;
  assign dbg_data   = regs_q[dbg_sel[RW-1:0]];

endmodule

// File: tb/tb_processador_multiciclo.sv
// Bench for processador_multiciclo (DATA_W=16, NREGS=8): directed program plus random
// instructions, each checked against an instruction-level reference model.
module tb_processador_multiciclo;

  logic        clock;
  logic        reset;
  logic        run;
  logic [15:0] Din;
  logic        done;
  logic [15:0] BusWires;
  logic        zero_flag;
  logic        carry_flag;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_data;

  int compared   = 0;
  int mismatched = 0;

  logic [15:0] m_r [8];
  logic        m_z, m_c;

  processador_multiciclo #(.DATA_W(16), .NREGS(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .Din        (Din),
    .done       (done),
    .BusWires   (BusWires),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_z = 1'b0;
    m_c = 1'b0;
  endtask

  // Idle-time comparison of the whole architectural state.
  task automatic check_state(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check($sformatf("%s r%0d", tag, i), dbg_data, m_r[i]);
    end
    check({tag, " Z"}, 16'(zero_flag), 16'(m_z));
    check({tag, " C"}, 16'(carry_flag), 16'(m_c));
    check({tag, " idle done"}, 16'(done), 16'h0000);
    check({tag, " idle bus"}, BusWires, 16'h0000);
  endtask

  task automatic exec(input logic [15:0] instr, input string tag);
    logic [2:0]  op;
    logic [15:0] a, b, res;
    logic [16:0] full;
    logic        wr, nz, nc;
    int          steps;
    op    = instr[15:13];
    a     = m_r[instr[11:9]];
    b     = instr[12] ? {7'b0, instr[8:0]} : m_r[instr[2:0]];
    nz    = m_z;
    nc    = m_c;
    wr    = 1'b1;
    steps = 3;
    res   = 16'h0000;
    case (op)
      3'd0: begin steps = 1; res = b; end
      3'd1: begin steps = 1; res = {instr[7:0], 8'h00}; end
      3'd6: begin steps = 1; res = b; wr = !m_z; end
      3'd2: begin full = 17'(a) + 17'(b); res = full[15:0]; nc = full[16]; end
      3'd3: begin res = a - b; nc = (a >= b); end
      3'd4: res = a & b;
      3'd5: res = a ^ b;
      default: begin res = a - b; nc = (a >= b); wr = 1'b0; end
    endcase
    if (steps == 3) nz = (res == 16'h0000);

    @(negedge clock);
    run = 1'b1;
    Din = instr;
    @(posedge clock);
    #1;
    for (int k = 1; k <= steps; k++) begin
      run = 1'($urandom);
      Din = 16'($urandom);
      @(negedge clock);
      check($sformatf("%s done step%0d", tag, k), 16'(done), 16'(k == steps));
      if (steps == 3 && k == 1) check({tag, " bus rX"}, BusWires, a);
      if (k == steps) check({tag, " bus result"}, BusWires, res);
      @(posedge clock);
      #1;
    end
    run = 1'b0;
    if (wr) m_r[instr[11:9]] = res;
    m_z = nz;
    m_c = nc;
    check_state(tag);
  endtask

  initial begin
    logic [15:0] instr;
    reset   = 1'b0;
    run     = 1'b0;
    Din     = 16'h0000;
    dbg_sel = 3'd0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("in reset done", 16'(done), 16'h0000);
    reset = 1'b1;

    // Idle with run low: nothing moves, done never rises.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check($sformatf("idle%0d done", i), 16'(done), 16'h0000);
    end
    check_state("post-reset");

    // Directed program.
    exec(16'h11FF, "mv r0,#1FF");
    exec(16'h32A5, "mvt r1,#A5");
    exec(16'h4200, "add r1,r0");
    exec(16'h6000, "sub r0,r0");
    exec(16'hD405, "mvnz r2,#5 Z=1");
    exec(16'h36FF, "mvt r3,#FF");
    exec(16'h5700, "add r3,#100");
    exec(16'hF600, "cmp r3,#0");
    exec(16'h4249, "add r1,r1");
    exec(16'hC403, "mvnz r2,r3 Z=0");
    exec(16'h8A01, "and r5,r1");
    exec(16'hA201, "xor r1,r1");

    // Random instructions.
    for (int n = 0; n < 40; n++) begin
      instr = 16'($urandom);
      exec(instr, $sformatf("rand%0d %h", n, instr));
    end

    // Reset asserted in T2 of add r1,#1 aborts the instruction.
    @(negedge clock);
    run = 1'b1;
    Din = 16'h5201;
    @(posedge clock);
    #1 run = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort done", 16'(done), 16'h0000);
    check("abort bus", BusWires, 16'h0000);
    model_reset();
    check_state("abort");

    // Release with run already high: fetch on the first edge after release.
    @(negedge clock);
    run   = 1'b1;
    Din   = 16'h1807;
    reset = 1'b1;
    @(posedge clock);
    #1 run = 1'b0;
    @(negedge clock);
    check("post-release done", 16'(done), 16'h0001);
    check("post-release bus", BusWires, 16'h0007);
    @(posedge clock);
    #1;
    m_r[4] = 16'h0007;
    check_state("post-release");
    exec(16'h5801, "add r4,#1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
